// File: rtl/mult_pkg.sv
// Shared types for the radix-16 Booth multiplier controller and datapath.
// FSM state enum, partial-product select encodings and the default width.
package mult_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIN
  } state_t;

  localparam logic [2:0] SEL_A_0  = 3'd0;
  localparam logic [2:0] SEL_A_1X = 3'd1;
  localparam logic [2:0] SEL_A_2X = 3'd2;
  localparam logic [2:0] SEL_A_4X = 3'd3;
  localparam logic [2:0] SEL_A_8X = 3'd4;

  localparam logic [1:0] SEL_B_0  = 2'd0;
  localparam logic [1:0] SEL_B_1X = 2'd1;
  localparam logic [1:0] SEL_B_2X = 2'd2;

  localparam logic       SEL_C_0  = 1'b0;
  localparam logic       SEL_C_1X = 1'b1;

endpackage

// File: rtl/booth16_digit_enc.sv
// Radix-16 Booth digit encoder: 5-bit window -> multiple selects + sign.
// Ports: i_win (window), o_sel_a/o_sel_b/o_sel_c (multiples), o_sign.
import mult_pkg::*;

module booth16_digit_enc (
  input  logic [4:0] i_win,
  output logic [2:0] o_sel_a,
  output logic [1:0] o_sel_b,
  output logic       o_sel_c,
  output logic       o_sign
);

  logic [4:0] w_d;
  logic [4:0] w_mag;
  logic       w_neg;

  // Signed value of w[4:1] plus the overlap bit w[0]: range -8..+8.
  assign w_d   = {i_win[4], i_win[4:1]} + {4'b0, i_win[0]};
  assign w_neg = w_d[4];
  assign w_mag = w_neg ? (5'd0 - w_d) : w_d;

  always_comb begin
    o_sel_a = SEL_A_0;
    o_sel_b = SEL_B_0;
    o_sel_c = SEL_C_0;
    o_sign  = w_neg & (w_mag != 5'd0);
    case (w_mag)
      5'd1: o_sel_a = SEL_A_1X;
      5'd2: o_sel_a = SEL_A_2X;
      5'd3: begin
        o_sel_a = SEL_A_2X;
        o_sel_b = SEL_B_1X;
      end
      5'd4: o_sel_a = SEL_A_4X;
      5'd5: begin
        o_sel_a = SEL_A_4X;
        o_sel_b = SEL_B_1X;
      end
      5'd6: begin
        o_sel_a = SEL_A_4X;
        o_sel_b = SEL_B_2X;
      end
      5'd7: begin
        o_sel_a = SEL_A_4X;
        o_sel_b = SEL_B_2X;
        o_sel_c = SEL_C_1X;
      end
      5'd8: o_sel_a = SEL_A_8X;
      default: ;
    endcase
  end

endmodule

// File: rtl/booth16_mult_ctrl.sv
// Radix-16 Booth multiplier sequencing controller (IDLE/LOAD/RUN/FIN).
// Ports: clk, rst, start, is_signed, B in; load_a, acc_clr, acc_en,
// shift_en, SelBoothA/B/C, Sign, busy, done out (all registered).
// Option: define MULT_EARLY_EXIT_EN to leave RUN once the digits left are 0.
import mult_pkg::*;

module booth16_mult_ctrl #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] B,
  output logic             load_a,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             shift_en,
  output logic [2:0]       SelBoothA,
  output logic [1:0]       SelBoothB,
  output logic             SelBoothC,
  output logic             Sign,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / 4 + 1;
  localparam int BW   = WIDTH + 5;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t        r_state;
  logic [BW-1:0] r_breg;
  logic [CW-1:0] r_cnt;

  logic [2:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_sel_c;
  logic       w_sign;
  logic       w_ext;
  logic       w_last;

  booth16_digit_enc u_enc (
    .i_win   (r_breg[4:0]),
    .o_sel_a (w_sel_a),
    .o_sel_b (w_sel_b),
    .o_sel_c (w_sel_c),
    .o_sign  (w_sign)
  );

  assign w_ext = is_signed & B[WIDTH-1];

  // r_breg already holds the window of the next digit, so a uniform
  // register means every digit still to come is zero.
`ifdef MULT_EARLY_EXIT_EN
  assign w_last = (r_cnt == LAST) ||
                  (r_breg == '0) || (r_breg == '1);
`else
  assign w_last = (r_cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_breg    <= '0;
      r_cnt     <= '0;
      load_a    <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      shift_en  <= 1'b0;
      SelBoothA <= SEL_A_0;
      SelBoothB <= SEL_B_0;
      SelBoothC <= SEL_C_0;
      Sign      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      load_a    <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      shift_en  <= 1'b0;
      SelBoothA <= SEL_A_0;
      SelBoothB <= SEL_B_0;
      SelBoothC <= SEL_C_0;
      Sign      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_breg  <= {{4{w_ext}}, B, 1'b0};
            r_state <= ST_LOAD;
            load_a  <= 1'b1;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state   <= ST_RUN;
          r_cnt     <= '0;
          busy      <= 1'b1;
          acc_en    <= 1'b1;
          shift_en  <= 1'b1;
          SelBoothA <= w_sel_a;
          SelBoothB <= w_sel_b;
          SelBoothC <= w_sel_c;
          Sign      <= w_sign;
          r_breg    <= {{4{r_breg[BW-1]}}, r_breg[BW-1:4]};
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_FIN;
            done    <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            busy      <= 1'b1;
            acc_en    <= 1'b1;
            shift_en  <= 1'b1;
            SelBoothA <= w_sel_a;
            SelBoothB <= w_sel_b;
            SelBoothC <= w_sel_c;
            Sign      <= w_sign;
            r_breg    <= {{4{r_breg[BW-1]}}, r_breg[BW-1:4]};
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth16_mult_ctrl.sv
// Testbench for booth16_mult_ctrl: random and directed multiplies checked
// against plain-arithmetic products via a small accumulator datapath model.
module tb_booth16_mult_ctrl;

  localparam int WIDTH = 32;
  localparam int NDIG  = WIDTH / 4 + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] B;
  logic             load_a, acc_clr, acc_en, shift_en;
  logic [2:0]       SelBoothA;
  logic [1:0]       SelBoothB;
  logic             SelBoothC, Sign, busy, done;

  logic [4:0] e_win;
  logic [2:0] e_a;
  logic [1:0] e_b;
  logic       e_c, e_s;

  int n_pass = 0;
  int n_tot  = 0;

  // |digit| -> multiples of A, B, C
  int TA [0:8] = '{0, 1, 2, 2, 4, 4, 4, 4, 8};
  int TB [0:8] = '{0, 0, 0, 1, 0, 1, 2, 2, 0};
  int TC [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  booth16_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .B(B),
    .load_a(load_a), .acc_clr(acc_clr), .acc_en(acc_en),
    .shift_en(shift_en), .SelBoothA(SelBoothA), .SelBoothB(SelBoothB),
    .SelBoothC(SelBoothC), .Sign(Sign), .busy(busy), .done(done)
  );

  booth16_digit_enc u_enc (
    .i_win(e_win), .o_sel_a(e_a), .o_sel_b(e_b), .o_sel_c(e_c), .o_sign(e_s)
  );

  function automatic int val_a(logic [2:0] c);
    case (c)
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 4;
      3'd4: return 8;
      default: return 99;
    endcase
  endfunction

  function automatic int val_b(logic [1:0] c);
    case (c)
      2'd0: return 0;
      2'd1: return 1;
      2'd2: return 2;
      default: return 99;
    endcase
  endfunction

  function automatic int digit_of(logic [WIDTH+4:0] bx, int k);
    return -8 * int'(bx[4*k+4]) + 4 * int'(bx[4*k+3]) +
           2 * int'(bx[4*k+2]) + int'(bx[4*k+1]) + int'(bx[4*k]);
  endfunction

  function automatic logic [12:0] outs();
    return {load_a, acc_clr, acc_en, shift_en, SelBoothA, SelBoothB,
            SelBoothC, Sign, busy, done};
  endfunction

  // Caller must be at a negedge; start is driven immediately.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, input int poke);
    logic [WIDTH+4:0] bx;
    longint unsigned a64, b64, expect_p, areg, acc, contrib;
    int dig [NDIG];
    int last_nz, exp_runs, runs, cyc, d, mag, va, vb, vc;
    bit seen_done;
    bx = {{4{sgn & b[31]}}, b, 1'b0};
    last_nz = 0;
    for (int k = 0; k < NDIG; k++) begin
      dig[k] = digit_of(bx, k);
      if (dig[k] != 0) last_nz = k;
    end
`ifdef MULT_EARLY_EXIT_EN
    exp_runs = last_nz + 1;
`else
    exp_runs = NDIG;
`endif
    a64 = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    b64 = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    expect_p = a64 * b64;
    B = b;
    is_signed = sgn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    B = $urandom;
    is_signed = 1'($urandom);
    n_tot++;
    if ({load_a, acc_clr, busy, acc_en, done} !== 5'b11100) begin
      $display("FAIL load_cycle b=%h got=%b want=11100", b,
               {load_a, acc_clr, busy, acc_en, done});
    end else n_pass++;
    areg = a64;
    acc = 0;
    cyc = 1;
    runs = 0;
    seen_done = 0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke) ? 1'b1 : 1'b0;
      if (done) begin
        seen_done = 1;
        n_tot++;
        if (cyc !== exp_runs + 2 || outs() !== 13'h001) begin
          $display("FAIL done_cycle b=%h cyc=%0d want=%0d outs=%h",
                   b, cyc, exp_runs + 2, outs());
        end else n_pass++;
      end else begin
        n_tot++;
        if (!acc_en || runs >= NDIG) begin
          $display("FAIL run_cycle b=%h cyc=%0d outs=%h runs=%0d",
                   b, cyc, outs(), runs);
        end else begin
          d = dig[runs];
          mag = (d < 0) ? -d : d;
          va = val_a(SelBoothA);
          vb = val_b(SelBoothB);
          vc = int'(SelBoothC);
          if (va != TA[mag] || vb != TB[mag] || vc != TC[mag] ||
              Sign !== (d < 0) || !busy || !shift_en || load_a) begin
            $display("FAIL digit%0d b=%h got=%0d,%0d,%0d s%b want=%0d,%0d,%0d s%0d",
                     runs, b, va, vb, vc, Sign, TA[mag], TB[mag], TC[mag],
                     int'(d < 0));
          end else n_pass++;
          contrib = longint'(va + vb + vc) * areg;
          if (Sign) acc = acc - contrib;
          else acc = acc + contrib;
          areg = areg << 4;
          runs++;
        end
      end
    end
    start = 1'b0;
    n_tot++;
    if (!seen_done || runs !== exp_runs) begin
      $display("FAIL run_count b=%h runs=%0d want=%0d done=%0d",
               b, runs, exp_runs, seen_done);
    end else n_pass++;
    n_tot++;
    if (acc !== expect_p) begin
      $display("FAIL product a=%h b=%h s=%0d got=%h want=%h",
               a, b, sgn, acc, expect_p);
    end else n_pass++;
    @(negedge clk);
    n_tot++;
    if (outs() !== 13'h000) begin
      $display("FAIL post_done_idle b=%h got=%h want=0000", b, outs());
    end else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    B = $urandom;
    is_signed = 1'b1;
    repeat (2) @(negedge clk);
    n_tot++;
    if (outs() !== 13'h000) begin
      $display("FAIL reset_outputs got=%h want=0000", outs());
    end else n_pass++;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_tot++;
    if (outs() !== 13'h000) begin
      $display("FAIL idle_no_start got=%h want=0000", outs());
    end else n_pass++;
  endtask

  task automatic test_encoder();
    int d, mag;
    for (int w = 0; w < 32; w++) begin
      e_win = 5'(w);
      #1;
      d = -8 * ((w >> 4) & 1) + 4 * ((w >> 3) & 1) + 2 * ((w >> 2) & 1) +
          ((w >> 1) & 1) + (w & 1);
      mag = (d < 0) ? -d : d;
      n_tot++;
      if (val_a(e_a) != TA[mag] || val_b(e_b) != TB[mag] ||
          int'(e_c) != TC[mag] || e_s !== (d < 0)) begin
        $display("FAIL enc w=%b got=%0d,%0d,%0d s%b want=%0d,%0d,%0d s%0d",
                 e_win, val_a(e_a), val_b(e_b), e_c, e_s,
                 TA[mag], TB[mag], TC[mag], int'(d < 0));
      end else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(32'd5, 32'h0000_0007, 1'b0, 0);
    run_op(32'd3, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0000_0003, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = b >> $urandom_range(31, 4);
      if (i % 3 == 2) b = 32'hFFFF_FFFF ^ (b >> $urandom_range(31, 4));
      run_op(a, b, 1'($urandom), 0);
    end
  endtask

  task automatic test_start_ignored();
    run_op($urandom, 32'h8765_4321, 1'b0, 5);
    run_op($urandom, 32'hF0F0_1234, 1'b1, 4);
  endtask

  task automatic test_reset_abort();
    bit bad_done;
    B = 32'h8765_4321;
    is_signed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tot++;
    if (outs() !== 13'h000) begin
      $display("FAIL abort_outputs got=%h want=0000", outs());
    end else n_pass++;
    bad_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (outs() !== 13'h000) bad_done = 1;
    end
    n_tot++;
    if (bad_done) begin
      $display("FAIL abort_quiet got=activity want=idle");
    end else n_pass++;
    run_op($urandom, $urandom, 1'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    B = '0;
    e_win = '0;
    @(negedge clk);
    test_reset();
    test_encoder();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/booth16_mult_ctrl.md
Name: booth16_mult_ctrl

Overview:
Sequencing controller for the radix-16 Booth multiplier datapath. It takes one multiply request, scans the multiplier four bits per cycle, and decodes each 5-bit overlapping window into the partial-product selects SelBoothA/SelBoothB/SelBoothC and the negate bit Sign. Each cycle it also strobes the multiplicand shift register (A <= A<<4) and the external accumulator. It sits between the MIPS ALU/HI-LO issue logic and the multiplier datapath.

Parameters:
WIDTH, 32, multiplier operand width; multiple of 4, at least 8.
NDIG, WIDTH/4+1, digit count; derived, not overridable; the extra digit covers unsigned operands.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request pulse; sampled only in IDLE
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
B  in  WIDTH  multiplier operand
load_a  out  1  datapath loads the extended multiplicand into the A register
acc_clr  out  1  clear the accumulator
acc_en  out  1  accumulator += BoothA+BoothB+BoothC this cycle
shift_en  out  1  A register <= AfterA (A<<4) this cycle
SelBoothA  out  3  0:0, 1:1x, 2:2x, 3:4x, 4:8x
SelBoothB  out  2  0:0, 1:1x, 2:2x
SelBoothC  out  1  0:0, 1:1x
Sign  out  1  negate the selected multiples (digit < 0)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; accumulator holds the final product

Behaviour:
- One clock domain (clk); rst is synchronous and active-high. Reset forces IDLE, and every output is 0 in the same edge.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE: when start=1, go to LOAD.
  - Capture Breg = {ext x4, B, 1'b0}, a (WIDTH+5)-bit register.
  - ext = B[WIDTH-1] when is_signed=1, else 0.
- LOAD: load_a=1, acc_clr=1, busy=1; cnt<=0; go to RUN.
- RUN: busy=1, acc_en=1, shift_en=1.
  - Window w = Breg[4:0]; digit d = -8*w[4] + 4*w[3] + 2*w[2] + w[1] + w[0], range -8..+8.
  - Sign = (d<0). Map |d| to (A,B,C) multiples:
    0:(0,0,0) 1:(1,0,0) 2:(2,0,0) 3:(2,1,0) 4:(4,0,0) 5:(4,1,0) 6:(4,2,0) 7:(4,2,1) 8:(8,0,0).
  - When d=0, force Sign=0.
  - Each cycle: Breg <= Breg>>4 (arithmetic), cnt++.
  - After the cycle with cnt=NDIG-1, go to FIN.
- FIN: done=1, busy=0, all selects 0; go to IDLE.
- Latency: start at edge 0; LOAD in cycle 1; RUN in cycles 2..NDIG+1; done in cycle NDIG+2 (cycle 11 for WIDTH=32).
- Outputs and selects are registered.
  - SelBooth*/Sign are valid exactly in cycles where acc_en=1.
  - In all other cycles they are 0.
- start while busy, or in LOAD/RUN/FIN: ignored, with no queueing. A new start is accepted the cycle after done.
- rst in any state aborts the operation: no done pulse, outputs 0 at the next edge.
- Multiplicand extension to 64 bits is the datapath's job, using the same is_signed value. Product = low 64 bits of the accumulator.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: in RUN, if all remaining bits of Breg (including bit 0) are equal, every remaining digit is 0.
  - The controller leaves RUN immediately after the current digit and goes to FIN.
  - Cycle count varies: at least 1 RUN cycle, at most NDIG.
  - The datapath must still see consistent shifts (the product is unaffected because the skipped digits are zero).
- Undefined: always exactly NDIG RUN cycles; fixed latency NDIG+2.

Decomposition:
- Shared package mult_pkg:
  - FSM state enum.
  - SEL_A_{0,1X,2X,4X,8X}, SEL_B_{0,1X,2X}, SEL_C_{0,1X} encodings (shared with the datapath muxes).
  - Default WIDTH.
- One sub-module, booth16_digit_enc: purely combinational, 5-bit window -> {SelBoothA, SelBoothB, SelBoothC, Sign}. Exhaustively testable over 32 inputs.

Test Plan:
- Encoder sweep, all 32 windows: d=sum of selected multiples with sign. w=5'b01111 -> d=+8 -> SelBoothA=4, B=0, C=0, Sign=0. w=5'b10000 -> d=-8 -> A=4, Sign=1. w=5'b11111 -> all 0, Sign=0.
- Unsigned B=32'h0000_0007, start: LOAD in cycle 1. First RUN digit d=7 -> (A=3, B=2, C=1, Sign=0); remaining digits 0. done in cycle 11; with the datapath model, 5*7=35.
- Signed B=32'hFFFF_FFFF (-1), A=3: first digit d=-1 -> SelBoothA=1, Sign=1; others 0. Product 64'hFFFF_FFFF_FFFF_FFFD.
- Unsigned B=32'hFFFF_FFFF: 9th digit d=+1 (Sign=0). 2*B = 64'h0000_0001_FFFF_FFFE.
- start pulsed during RUN is ignored; rst asserted in cycle 5 gives all outputs 0 next edge and no done; a fresh start then completes normally.
- MULT_EARLY_EXIT_EN: B=32'h0000_0003 unsigned -> exactly 1 RUN cycle, done in cycle 3. Without the macro, done in cycle 11.
